// File: rtl/network_sequencer.sv
// Inference sequencer for the stochastic bitstream network: accept a vector,
// settle, flush the integrators, run a fixed window, capture and hand the counts downstream.
module network_sequencer #(
  parameter int INPUT_SIZE    = 4,
  parameter int OUTPUT_SIZE   = 3,
  parameter int STREAM_LEN    = 256,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic in_valid,
  output logic in_ready,
  input  int   in_data    [INPUT_SIZE],
  output int   net_input  [INPUT_SIZE],
  output logic net_compute,
  input  int   net_output [OUTPUT_SIZE],
  output logic out_valid,
  input  logic out_ready,
  output int   out_data   [OUTPUT_SIZE],
  output logic busy
);

  // state   | meaning
  // IDLE    | waiting for an input vector (in_ready high)
  // SETTLE  | inputs loaded, letting the layer pipeline settle
  // FLUSH   | compute pulse that discards counts from the previous input
  // RUN     | bitstream window of STREAM_LEN cycles
  // CAPTURE | compute pulse that captures the window's counts
  // LATCH   | captured counts are on net_output; register them
  // DONE    | result presented until out_ready

  localparam int CNT_MAX = (STREAM_LEN > SETTLE_CYCLES) ? STREAM_LEN : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] RUN_LAST    = CW'(STREAM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_FLUSH, S_RUN, S_CAPTURE, S_LATCH, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = (SETTLE_CYCLES == 0) ? S_FLUSH : S_SETTLE;
          cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == SETTLE_LAST) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // the terminal value STREAM_LEN still fits in CW bits, so no wrap
        cnt_nxt = cnt + CW'(1);
        if (cnt == RUN_LAST) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: state_nxt = S_LATCH;
      S_LATCH:   state_nxt = S_DONE;
      S_DONE:    if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      net_compute <= 1'b0;
      net_input   <= '{default: 0};
      out_data    <= '{default: 0};
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      // registered from the next state so the pulse lines up with FLUSH/CAPTURE
      net_compute <= (state_nxt == S_FLUSH) || (state_nxt == S_CAPTURE);
      if (state == S_IDLE && in_valid) net_input <= in_data;
      if (state == S_LATCH) out_data <= net_output;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
- Inference controller for the stochastic bitstream network.
- Accepts one input vector per inference through a valid/ready handshake and holds it stable on the network inputs.
- Flushes the output integrators, runs the bitstream for a fixed window, then pulses capture.
- Latches the integrated counts and presents them downstream with a valid/ready handshake.

Parameters:
- INPUT_SIZE, 4, number of network inputs (int lanes).
- OUTPUT_SIZE, 3, number of network outputs (int lanes).
- STREAM_LEN, 256, bitstream window in cycles between flush and capture; legal range 1..65535.
- SETTLE_CYCLES, 8, cycles after loading inputs before the flush pulse, so the layer pipeline settles; 0 is legal and skips SETTLE.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- n_rst  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input vector valid.
- in_ready  output  1  sequencer can accept a vector.
- in_data  input  int[0:INPUT_SIZE-1]  input vector.
- net_input  output  int[0:INPUT_SIZE-1]  drives network_input; registered.
- net_compute  output  1  drives network compute (integrator capture); registered.
- net_output  input  int[0:OUTPUT_SIZE-1]  from network_output.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  int[0:OUTPUT_SIZE-1]  latched result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, in_ready=1, net_input all 0, net_compute=0, out_valid=0, out_data all 0, busy=0, counter=0. Reset mid-inference aborts it; no result is produced.
- Integrator contract: integrators capture on the edge where compute=1 and restart counting. net_output is valid from the following cycle.
- States: IDLE, SETTLE, FLUSH, RUN, CAPTURE, LATCH, DONE. Counter width is $clog2(max(STREAM_LEN, SETTLE_CYCLES)+1).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: net_input<=in_data; counter<=0; go to SETTLE (or FLUSH if SETTLE_CYCLES=0).
- SETTLE: counter increments each cycle. After exactly SETTLE_CYCLES cycles in this state, go to FLUSH.
- FLUSH:
  - Exactly 1 cycle, net_compute=1.
  - The capture discards counts accumulated from the previous input.
  - Counter cleared; go to RUN.
- RUN: net_compute=0 for exactly STREAM_LEN cycles, then go to CAPTURE.
- CAPTURE: exactly 1 cycle, net_compute=1; go to LATCH.
- LATCH: 1 cycle; out_data<=net_output at the end of the cycle; go to DONE.
- DONE:
  - out_valid=1 and out_data held stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE the next cycle.
  - out_ready may already be high on the first DONE cycle; the sequencer then spends exactly 1 cycle in DONE.
- net_compute is driven only from a register, high only in FLUSH and CAPTURE. It is never high 2 consecutive cycles.
- in_ready=0 in all states except IDLE. in_valid outside IDLE is ignored and in_data is not sampled. net_input holds its value from accept until the next accept.
- Latency: the accept edge to the first out_valid=1 cycle is SETTLE_CYCLES+STREAM_LEN+3 cycles. The minimum period between accepts is SETTLE_CYCLES+STREAM_LEN+5 cycles with out_ready held high.
- Counter must not wrap. STREAM_LEN=1 gives a single RUN cycle.

Test Plan:
- Basic run:
  - Setup: STREAM_LEN=16, SETTLE_CYCLES=4, out_ready=1. Stimulus: accept in_data={10,20,30,40}.
  - Checks: net_input={10,20,30,40} the cycle after accept. net_compute high on exactly 2 cycles, 17 cycles apart. out_valid rises 23 cycles after the accept edge. busy is high throughout.
- Result latching:
  - Stimulus: the bench integrator model presents net_output={7,3,12} the cycle after CAPTURE.
  - Checks: out_data={7,3,12} on out_valid. Changing net_output afterwards leaves out_data unchanged.
- Backpressure:
  - Stimulus: hold out_ready=0 for 50 cycles in DONE.
  - Checks: out_valid stays 1, out_data is stable, in_ready=0, and in_valid pulses are ignored. After out_ready=1, in_ready=1 on the next cycle.
- Back-to-back:
  - Stimulus: in_valid held high with 2 distinct vectors and out_ready=1.
  - Checks: the second accept occurs exactly 25 cycles after the first. The second result is independent of the first, because the FLUSH pulse is present.
- Reset mid-RUN:
  - Stimulus: assert n_rst=0 at RUN cycle 5, asynchronously (between clock edges).
  - Checks: outputs go to reset values immediately. No out_valid occurs. A new accept after release completes normally.
- Edge parameters:
  - Stimulus: SETTLE_CYCLES=0, STREAM_LEN=1.
  - Checks: FLUSH is the cycle right after accept. The CAPTURE pulse occurs 2 cycles after the FLUSH pulse. out_valid rises 4 cycles after the accept edge.
